lut_ff_mux_cell: RTL and testbench

- Single logic-element primitive: a 4-input look-up table (LUT4), a D flip-flop on the LUT output, and a 2:1 output mux.
- The mux selects between the combinational LUT result and the registered result.
- Used as a basic cell in place-and-route evaluation; the cell is checked against its post-route netlist, so behaviour must be exactly cycle-equivalent.

---
 rtl/lut_ff_mux_cell_if.sv | 18 +
 rtl/lut_ff_mux_cell.sv | 37 +++
 tb/tb_lut_ff_mux_cell.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lut_ff_mux_cell_if.sv
// Signal bundle for the lut_ff_mux_cell logic element.
// The optional ce wire exists only when LUT_FF_MUX_CE_EN is defined.
interface lut_ff_mux_cell_if;
    logic [3:0] in;
    logic       mux_sel;
`ifdef LUT_FF_MUX_CE_EN
    logic       ce;
`endif
    logic       Q;

`ifdef LUT_FF_MUX_CE_EN
    modport master (output in, output mux_sel, output ce, input Q);
    modport slave  (input in, input mux_sel, input ce, output Q);
`else
    modport master (output in, output mux_sel, input Q);
    modport slave  (input in, input mux_sel, output Q);
`endif
endinterface

// File: rtl/lut_ff_mux_cell.sv
// lut_ff_mux_cell: LUT4 -> D flip-flop -> 2:1 output mux logic element.
// Q selects the combinational LUT result (mux_sel = 0) or the registered
// result (mux_sel = 1). Defining LUT_FF_MUX_CE_EN adds a flip-flop clock
// enable (bus.ce); without it the flip-flop loads on every rising edge.
module lut_ff_mux_cell #(
    parameter logic [15:0] LUT_INIT = 16'h6996,
    parameter logic        RST_VAL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    lut_ff_mux_cell_if.slave   bus
);

    logic lut_out;
    logic ff_q;

    // Table lookup: in[0] is the LSB of the index, no reset gating.
    assign lut_out = LUT_INIT[bus.in];

    // Single state bit; reset is asynchronous and takes priority over any edge.
    // NOTE: non-blocking assignment keeps the register update race-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= RST_VAL;
`ifdef LUT_FF_MUX_CE_EN
        end else if (bus.ce) begin
`else
        end else begin
`endif
            ff_q <= lut_out;
        end
    end

    // Output mux: a change on mux_sel reaches Q without waiting for a clock.
    assign bus.Q = bus.mux_sel ? ff_q : lut_out;

endmodule

// File: tb/tb_lut_ff_mux_cell.sv
// Self-checking bench for lut_ff_mux_cell. Stimulus pushes the expected Q
// into a scoreboard queue and raises an event; a separate monitor pops and
// compares. Build with LUT_FF_MUX_CE_EN defined to exercise the clock enable.
module tb_lut_ff_mux_cell;

    localparam logic [15:0] LUT_INIT = 16'h6996;
    localparam logic        RST_VAL  = 1'b0;

    typedef struct {
        string name;
        logic  exp;
    } sb_entry_t;

    logic clk;
    logic rst;

    lut_ff_mux_cell_if bus ();

    lut_ff_mux_cell #(
        .LUT_INIT (LUT_INIT),
        .RST_VAL  (RST_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sb_entry_t sb_q[$];
    event      sample_ev;
    int        n_checks = 0;
    int        n_pass   = 0;

    // Free-running clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: each sample event pops one expectation and compares Q.
    initial begin
        sb_entry_t e;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (bus.Q === e.exp)
                    n_pass++;
                else
                    $display("FAIL %s: Q=%b expected %b at %0t", e.name, bus.Q, e.exp, $time);
            end
        end
    end

    function automatic logic lut(input logic [3:0] idx);
        return LUT_INIT[idx];
    endfunction

    task automatic expect_q(input string name, input logic exp);
        sb_entry_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    initial begin
        logic [3:0] x;
        logic       s;
        logic       ff_exp;

        rst         = 1'b1;
        bus.in      = 4'b0000;
        bus.mux_sel = 1'b0;
`ifdef LUT_FF_MUX_CE_EN
        bus.ce      = 1'b1;
`endif
        #1;
        // Reset: combinational path is live, registered path holds RST_VAL.
        expect_q("rst_comb_in0", 1'b0);
        bus.in = 4'b0100;
        #1 expect_q("rst_comb_in4", 1'b1);
        bus.in      = 4'b0001;
        bus.mux_sel = 1'b1;
        #1 expect_q("rst_ff", 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1 expect_q("rst_ff_edge", 1'b0);
        end

        // Combinational path, no clock edge between the two checks.
        @(negedge clk);
        rst         = 1'b0;
        bus.mux_sel = 1'b0;
        bus.in      = 4'b0100;
        #1 expect_q("comb_0100", 1'b1);
        bus.in = 4'b0011;
        #1 expect_q("comb_0011", 1'b0);

        // Registered path: ff loaded lut(0011)=0 on the last edge.
        @(negedge clk);
        bus.in      = 4'b0001;
        bus.mux_sel = 1'b1;
        #1 expect_q("reg_before_edge", 1'b0);
        @(posedge clk);
        #1 expect_q("reg_after_edge", 1'b1);
        @(negedge clk);
        bus.in = 4'b0011;
        #1 expect_q("reg_hold", 1'b1);
        @(posedge clk);
        #1 expect_q("reg_update", 1'b0);

        // Async reset between edges, then release.
        @(negedge clk);
        bus.in = 4'b0001;
        @(posedge clk);
        #1 expect_q("async_ff_set", 1'b1);
        #1 rst = 1'b1;
        #1 expect_q("async_rst", 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        bus.in = 4'b1000;
        #1 expect_q("release_before_edge", 1'b0);
        @(posedge clk);
        #1 expect_q("release_after_edge", 1'b1);

`ifdef LUT_FF_MUX_CE_EN
        // Clock enable: hold over three edges with ce low, follow once high.
        @(negedge clk);
        bus.in = 4'b0001;
        @(posedge clk);
        #1 expect_q("ce_load", 1'b1);
        bus.ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in = (i % 2 == 0) ? 4'b0011 : 4'b0001;
            @(posedge clk);
            #1 expect_q("ce_hold", 1'b1);
        end
        @(negedge clk);
        bus.ce = 1'b1;
        bus.in = 4'b0011;
        #1 expect_q("ce_pre_edge", 1'b1);
        @(posedge clk);
        #1 expect_q("ce_follow", 1'b0);
`endif

        // Random sweep: each vector held two cycles, checked at both negedges.
        @(negedge clk);
        bus.in = 4'b0000;
        @(negedge clk);
        ff_exp = lut(4'b0000);
        for (int i = 0; i < 100; i++) begin
            x = 4'($urandom_range(0, 15));
            s = 1'($urandom_range(0, 1));
            @(negedge clk);
            bus.in      = x;
            bus.mux_sel = s;
            #1 expect_q("sweep_first", s ? ff_exp : lut(x));
            @(negedge clk);
            #1 expect_q("sweep_second", lut(x));
            ff_exp = lut(x);
        end

        // Bounded drain of the scoreboard before reporting.
        for (int i = 0; i < 100 && sb_q.size() > 0; i++) #1;
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
